elgamal_job_sequencer: RTL and testbench

Sequencer for the elliptic-curve ElGamal encryption flow. It time-shares one external scalar-multiplication engine, a point_gen-style unit with a start/ready handshake, across the three scalar products of one encryption:

- E2 = d·E1
- C1 = r·E1
- S = r·E2

It then drives the combinational pointAddition unit to form C2 = M + S. It replaces the fixed per-product engine instances in the encryption top level with a single engine plus this controller. It reports completion with a one-cycle done pulse and flags engine hangs.

---
 rtl/elgamal_job_sequencer_if.sv | 26 ++
 rtl/elgamal_job_sequencer.sv | 262 ++++++++++++++++++++++++++
 tb/tb_elgamal_job_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/elgamal_job_sequencer_if.sv
// Handshake bundle between the ElGamal job sequencer and the shared
// scalar-multiplication engine (start/ready, scalar, point in, point out).
interface elgamal_job_sequencer_if #(
    parameter int N   = 3,
    parameter int K_W = 3
);
    logic           mul_start;
    logic [K_W-1:0] mul_k;
    logic [N-1:0]   mul_X0;
    logic [N-1:0]   mul_Y0;
    logic [N-1:0]   mul_Z0;
    logic [N-1:0]   mul_X1;
    logic [N-1:0]   mul_Y1;
    logic [N-1:0]   mul_Z1;
    logic           mul_ready;

    modport master (
        output mul_start, mul_k, mul_X0, mul_Y0, mul_Z0,
        input  mul_X1, mul_Y1, mul_Z1, mul_ready
    );

    modport slave (
        input  mul_start, mul_k, mul_X0, mul_Y0, mul_Z0,
        output mul_X1, mul_Y1, mul_Z1, mul_ready
    );
endinterface

// File: rtl/elgamal_job_sequencer.sv
// Time-shares one scalar-multiplication engine across E2=d*E1, C1=r*E1 and
// S=r*E2, then forms C2=M+S through the external combinational adder.
module elgamal_job_sequencer #(
    parameter int N       = 3,
    parameter int K_W     = 3,
    parameter int TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [K_W-1:0]          d_key,
    input  logic [K_W-1:0]          r_key,
    input  logic [N-1:0]            e1_X0,
    input  logic [N-1:0]            e1_Y0,
    input  logic [N-1:0]            e1_Z0,
    input  logic [N-1:0]            pt_X,
    input  logic [N-1:0]            pt_Y,
    input  logic [N-1:0]            pt_Z,
    elgamal_job_sequencer_if.master eng,
    output logic [N-1:0]            add_X0,
    output logic [N-1:0]            add_Y0,
    output logic [N-1:0]            add_Z0,
    output logic [N-1:0]            add_X1,
    output logic [N-1:0]            add_Y1,
    output logic [N-1:0]            add_Z1,
    input  logic [N-1:0]            add_X2,
    input  logic [N-1:0]            add_Y2,
    input  logic [N-1:0]            add_Z2,
    output logic [N-1:0]            x_C1,
    output logic [N-1:0]            y_C1,
    output logic [N-1:0]            z_C1,
    output logic [N-1:0]            x_C2,
    output logic [N-1:0]            y_C2,
    output logic [N-1:0]            z_C2,
    output logic                    busy,
    output logic                    done,
    output logic                    error
);
    localparam int CW = $clog2(TIMEOUT + 1);

    // Packed projective point: [0]=X, [1]=Y, [2]=Z
    typedef logic [2:0][N-1:0] point_t;
    localparam point_t P_INF = point_t'({{N{1'b0}}, N'(1), {N{1'b0}}});

    typedef enum logic [3:0] {
        S_IDLE,
        S_E2_ISSUE,
        S_E2_WAIT,
        S_C1_ISSUE,
        S_C1_WAIT,
        S_S_ISSUE,
        S_S_WAIT,
        S_ADD,
        S_FINISH
    } state_t;

    state_t         r_state;
    state_t         w_state_next;
    state_t         w_wait_state;
    state_t         w_after_job;

    logic [K_W-1:0] r_d;
    logic [K_W-1:0] r_r;
    point_t         r_e1;
    point_t         r_m;
    point_t         r_e2;
    point_t         r_c1;
    point_t         r_s;
    point_t         r_c2;
    point_t         r_out_c1;
    point_t         r_out_c2;
    logic [CW-1:0]  r_cnt;
    logic           r_abort;

    point_t         w_e1_in;
    point_t         w_m_in;
    point_t         w_mul_res;
    point_t         w_add_res;
    point_t         w_op_pt;
    point_t         w_job_val;
    logic [K_W-1:0] w_op_k;
    logic           w_skip;
    logic           w_mul_start;
    logic           w_ld_in;
    logic           w_ld_job;
    logic           w_ld_c2;
    logic           w_cnt_clr;
    logic           w_cnt_inc;
    logic           w_abort_set;
    logic           w_done;
    logic           w_error;

    assign w_e1_in   = {e1_Z0, e1_Y0, e1_X0};
    assign w_m_in    = {pt_Z, pt_Y, pt_X};
    assign w_mul_res = {eng.mul_Z1, eng.mul_Y1, eng.mul_X1};
    assign w_add_res = {add_Z2, add_Y2, add_X2};

    // Operands come purely from registers, so they hold steady from ISSUE
    // through the matching WAIT and fall to zero outside the job states.
    always_comb begin
        w_op_k       = '0;
        w_op_pt      = '0;
        w_wait_state = S_IDLE;
        w_after_job  = S_IDLE;
        case (r_state)
            S_E2_ISSUE, S_E2_WAIT: begin
                w_op_k       = r_d;
                w_op_pt      = r_e1;
                w_wait_state = S_E2_WAIT;
                w_after_job  = S_C1_ISSUE;
            end
            S_C1_ISSUE, S_C1_WAIT: begin
                w_op_k       = r_r;
                w_op_pt      = r_e1;
                w_wait_state = S_C1_WAIT;
                w_after_job  = S_S_ISSUE;
            end
            S_S_ISSUE, S_S_WAIT: begin
                w_op_k       = r_r;
                w_op_pt      = r_e2;
                w_wait_state = S_S_WAIT;
                w_after_job  = S_ADD;
            end
            default: begin
                w_op_k       = '0;
                w_op_pt      = '0;
                w_wait_state = S_IDLE;
                w_after_job  = S_IDLE;
            end
        endcase
        w_skip = (w_op_k == '0) || (w_op_pt[2] == '0);
    end

    always_comb begin
        w_state_next = r_state;
        w_mul_start  = 1'b0;
        w_ld_in      = 1'b0;
        w_ld_job     = 1'b0;
        w_ld_c2      = 1'b0;
        w_cnt_clr    = 1'b0;
        w_cnt_inc    = 1'b0;
        w_abort_set  = 1'b0;
        w_done       = 1'b0;
        w_error      = 1'b0;
        w_job_val    = w_mul_res;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_ld_in      = 1'b1;
                    w_state_next = S_E2_ISSUE;
                end
            end
            S_E2_ISSUE, S_C1_ISSUE, S_S_ISSUE: begin
                w_cnt_clr = 1'b1;
                // A zero scalar or a point at infinity needs no engine job
                if (w_skip) begin
                    w_ld_job     = 1'b1;
                    w_job_val    = P_INF;
                    w_state_next = w_after_job;
                end else begin
                    w_mul_start  = 1'b1;
                    w_state_next = w_wait_state;
                end
            end
            S_E2_WAIT, S_C1_WAIT, S_S_WAIT: begin
                if (eng.mul_ready) begin
                    w_ld_job     = 1'b1;
                    w_state_next = w_after_job;
                end else if (r_cnt == CW'(TIMEOUT)) begin
                    w_abort_set  = 1'b1;
                    w_state_next = S_FINISH;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            S_ADD: begin
                w_ld_c2      = 1'b1;
                w_state_next = S_FINISH;
            end
            S_FINISH: begin
                w_done       = 1'b1;
                w_error      = r_abort;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_d      <= '0;
            r_r      <= '0;
            r_e1     <= '0;
            r_m      <= '0;
            r_e2     <= '0;
            r_c1     <= '0;
            r_s      <= '0;
            r_c2     <= '0;
            r_out_c1 <= '0;
            r_out_c2 <= '0;
            r_cnt    <= '0;
            r_abort  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_ld_in) begin
                r_d     <= d_key;
                r_r     <= r_key;
                r_e1    <= w_e1_in;
                r_m     <= w_m_in;
                r_abort <= 1'b0;
            end
            if (w_cnt_clr) begin
                r_cnt <= '0;
            end else if (w_cnt_inc) begin
                r_cnt <= r_cnt + CW'(1);
            end
            if (w_abort_set) begin
                r_abort <= 1'b1;
            end
            if (w_ld_job) begin
                case (r_state)
                    S_E2_ISSUE, S_E2_WAIT: r_e2 <= w_job_val;
                    S_C1_ISSUE, S_C1_WAIT: r_c1 <= w_job_val;
                    default:               r_s  <= w_job_val;
                endcase
            end
            // Ciphertext outputs become visible together with done
            if (w_ld_c2) begin
                r_c2     <= w_add_res;
                r_out_c1 <= r_c1;
                r_out_c2 <= w_add_res;
            end
        end
    end

    assign eng.mul_start = w_mul_start;
    assign eng.mul_k     = w_op_k;
    assign eng.mul_X0    = w_op_pt[0];
    assign eng.mul_Y0    = w_op_pt[1];
    assign eng.mul_Z0    = w_op_pt[2];

    assign add_X0 = r_m[0];
    assign add_Y0 = r_m[1];
    assign add_Z0 = r_m[2];
    assign add_X1 = r_s[0];
    assign add_Y1 = r_s[1];
    assign add_Z1 = r_s[2];

    assign x_C1 = r_out_c1[0];
    assign y_C1 = r_out_c1[1];
    assign z_C1 = r_out_c1[2];
    assign x_C2 = r_out_c2[0];
    assign y_C2 = r_out_c2[1];
    assign z_C2 = r_out_c2[2];

    assign busy  = (r_state != S_IDLE);
    assign done  = w_done;
    assign error = w_error;
endmodule

// File: tb/tb_elgamal_job_sequencer.sv
// Scoreboard bench for elgamal_job_sequencer with a toy engine/adder model:
// k*P = (k*X, k*Y, Z) mod 8, and P+Q sums components unless one has Z=0.
`timescale 1ns/1ps
module tb_elgamal_job_sequencer;
    localparam int N   = 3;
    localparam int K_W = 3;
    localparam int TO  = 8;
    localparam int L   = 4;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [2:0] d_key = '0, r_key = '0;
    logic [2:0] e1_X0 = '0, e1_Y0 = '0, e1_Z0 = '0;
    logic [2:0] pt_X = '0, pt_Y = '0, pt_Z = '0;
    logic [2:0] add_X0, add_Y0, add_Z0, add_X1, add_Y1, add_Z1;
    logic [2:0] add_X2, add_Y2, add_Z2;
    logic [2:0] x_C1, y_C1, z_C1, x_C2, y_C2, z_C2;
    logic       busy, done, error;

    elgamal_job_sequencer_if #(.N(N), .K_W(K_W)) eng_if ();

    elgamal_job_sequencer #(.N(N), .K_W(K_W), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .start(start),
        .d_key(d_key), .r_key(r_key),
        .e1_X0(e1_X0), .e1_Y0(e1_Y0), .e1_Z0(e1_Z0),
        .pt_X(pt_X), .pt_Y(pt_Y), .pt_Z(pt_Z),
        .eng(eng_if),
        .add_X0(add_X0), .add_Y0(add_Y0), .add_Z0(add_Z0),
        .add_X1(add_X1), .add_Y1(add_Y1), .add_Z1(add_Z1),
        .add_X2(add_X2), .add_Y2(add_Y2), .add_Z2(add_Z2),
        .x_C1(x_C1), .y_C1(y_C1), .z_C1(z_C1),
        .x_C2(x_C2), .y_C2(y_C2), .z_C2(z_C2),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Toy adder: point at infinity (Z=0) is the identity
    always_comb begin
        if (add_Z1 == 3'd0)
            {add_X2, add_Y2, add_Z2} = {add_X0, add_Y0, add_Z0};
        else if (add_Z0 == 3'd0)
            {add_X2, add_Y2, add_Z2} = {add_X1, add_Y1, add_Z1};
        else
            {add_X2, add_Y2, add_Z2} = {add_X0 + add_X1, add_Y0 + add_Y1, add_Z0 + add_Z1};
    end

    function automatic logic [8:0] pmul(input logic [2:0] k, input logic [2:0] x,
                                        input logic [2:0] y, input logic [2:0] z);
        logic [5:0] px, py;
        px = k * x;
        py = k * y;
        return {px[2:0], py[2:0], z};
    endfunction

    // Engine model: ready L cycles after start, optional hang, optional stale-high ready
    int         eng_cnt  = 0;
    int         eng_n    = 0;
    int         hang_nth = 0;
    bit         stale    = 1'b0;
    logic [2:0] e_k = '0, e_x = '0, e_y = '0, e_z = '0;
    logic [8:0] eng_res;

    always @(posedge clk) begin
        if (start && !busy && !reset) eng_n <= 0;
        else if (eng_if.mul_start) eng_n <= eng_n + 1;
        if (eng_if.mul_start && !stale) begin
            eng_cnt <= (hang_nth == eng_n + 1) ? 0 : L;
            e_k <= eng_if.mul_k;
            e_x <= eng_if.mul_X0;
            e_y <= eng_if.mul_Y0;
            e_z <= eng_if.mul_Z0;
        end else if (eng_cnt > 0) begin
            eng_cnt <= eng_cnt - 1;
        end
    end

    assign eng_res = stale ? pmul(eng_if.mul_k, eng_if.mul_X0, eng_if.mul_Y0, eng_if.mul_Z0)
                           : pmul(e_k, e_x, e_y, e_z);
    assign eng_if.mul_X1    = eng_res[8:6];
    assign eng_if.mul_Y1    = eng_res[5:3];
    assign eng_if.mul_Z1    = eng_res[2:0];
    assign eng_if.mul_ready = stale ? 1'b1 : (eng_cnt == 1);

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, req);
    endtask

    typedef struct {
        int         off;
        bit         err;
        logic [8:0] c1;
        logic [8:0] c2;
        int         nms;
        logic [8:0] ks;
        int         o0;
        int         o1;
        int         o2;
    } exp_t;

    exp_t sb_q[$];

    task automatic push_exp(input int off, input bit err, input logic [8:0] c1,
                            input logic [8:0] c2, input int nms, input logic [8:0] ks,
                            input int o0, input int o1, input int o2);
        exp_t e;
        e.off = off; e.err = err; e.c1 = c1; e.c2 = c2;
        e.nms = nms; e.ks = ks; e.o0 = o0; e.o1 = o1; e.o2 = o2;
        sb_q.push_back(e);
    endtask

    // Monitor: tracks each accepted run and scores it when done appears
    int         mon_t0 = 0;
    int         mon_n  = 0;
    int         mon_o[3];
    logic [8:0] mon_ks = '0;
    bit         prev_done = 1'b0;
    int         n_done = 0;

    always @(negedge clk) begin
        if (!reset) begin
            if (start && !busy) begin
                mon_t0 = cyc;
                mon_n  = 0;
                mon_ks = '0;
                for (int i = 0; i < 3; i++) mon_o[i] = -1;
            end
            if (eng_if.mul_start) begin
                if (mon_n < 3) mon_o[mon_n] = cyc - mon_t0;
                mon_ks = {mon_ks[5:0], eng_if.mul_k};
                mon_n++;
            end
            if (done) begin
                exp_t e;
                n_done++;
                $display("done #%0d at +%0d err=%0b C1=%h C2=%h starts=%0d", n_done,
                         cyc - mon_t0, error, {x_C1, y_C1, z_C1}, {x_C2, y_C2, z_C2}, mon_n);
                check("done_single", 32'(prev_done), 0);
                check("done_expected", 32'(sb_q.size() > 0), 1);
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    check("done_cycle", cyc - mon_t0, e.off);
                    check("error", 32'(error), 32'(e.err));
                    check("c1", 32'({x_C1, y_C1, z_C1}), 32'(e.c1));
                    check("c2", 32'({x_C2, y_C2, z_C2}), 32'(e.c2));
                    check("mul_start_count", mon_n, e.nms);
                    check("mul_k_seq", 32'(mon_ks), 32'(e.ks));
                    if (e.o0 >= 0) check("mul_start_cyc0", mon_o[0], e.o0);
                    if (e.o1 >= 0) check("mul_start_cyc1", mon_o[1], e.o1);
                    if (e.o2 >= 0) check("mul_start_cyc2", mon_o[2], e.o2);
                end
            end
            prev_done = done;
        end else begin
            prev_done = 1'b0;
        end
    end

    task automatic start_run(input logic [2:0] d, input logic [2:0] r,
                             input logic [8:0] e1, input logic [8:0] m);
        @(posedge clk); #1;
        d_key = d; r_key = r;
        {e1_X0, e1_Y0, e1_Z0} = e1;
        {pt_X, pt_Y, pt_Z} = m;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < budget && !seen; k++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            check("done_within_budget", 0, 1);
            if (sb_q.size() > 0) sb_q.delete(0);
        end
    endtask

    localparam logic [8:0] E1_A = {3'd1, 3'd2, 3'd1};
    localparam logic [8:0] M_A  = {3'd3, 3'd1, 3'd1};
    localparam logic [8:0] C1_A = {3'd3, 3'd6, 3'd1};
    localparam logic [8:0] C2_A = {3'd1, 3'd5, 3'd2};
    localparam logic [8:0] E1_B = {3'd2, 3'd1, 3'd1};
    localparam logic [8:0] M_B  = {3'd1, 3'd2, 3'd3};
    localparam logic [8:0] C1_B = {3'd2, 3'd1, 3'd1};
    localparam logic [8:0] C2_B = {3'd7, 3'd5, 3'd4};
    localparam logic [8:0] INF  = {3'd0, 3'd1, 3'd0};
    localparam logic [8:0] KS_A = {3'd2, 3'd3, 3'd3};
    localparam logic [8:0] KS_B = {3'd3, 3'd1, 3'd1};

    initial begin
        bit quiet;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_done_err", 32'({done, error}), 0);
        check("rst_mul", 32'({eng_if.mul_start, eng_if.mul_k, eng_if.mul_X0,
                               eng_if.mul_Y0, eng_if.mul_Z0}), 0);
        check("rst_ct", 32'({x_C1, y_C1, z_C1, x_C2, y_C2, z_C2}), 0);
        check("rst_add", 32'({add_X0, add_Y0, add_Z0, add_X1, add_Y1, add_Z1}), 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Nominal L=4 run
        push_exp(5 + 3 * L, 0, C1_A, C2_A, 3, KS_A, 1, 6, 11);
        start_run(3'd2, 3'd3, E1_A, M_A);
        wait_done(80);

        // r=0: only the E2 job is issued
        push_exp(5 + L, 0, INF, M_A, 1, 9'd2, 1, -1, -1);
        start_run(3'd2, 3'd0, E1_A, M_A);
        wait_done(80);

        // E1 at infinity: all three jobs skipped
        push_exp(5, 0, INF, {3'd5, 3'd6, 3'd7}, 0, 9'd0, -1, -1, -1);
        start_run(3'd2, 3'd3, {3'd1, 3'd2, 3'd0}, {3'd5, 3'd6, 3'd7});
        wait_done(80);

        // start re-pulsed at cycles 3 and 10 with different inputs
        push_exp(5 + 3 * L, 0, C1_A, C2_A, 3, KS_A, 1, 6, 11);
        start_run(3'd2, 3'd3, E1_A, M_A);
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1; d_key = 3'd7; r_key = 3'd5;
        {e1_X0, e1_Y0, e1_Z0} = 9'h1ff;
        {pt_X, pt_Y, pt_Z} = 9'h155;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(80);

        // Engine hangs on the C1 job: abort keeps the previous ciphertext
        hang_nth = 2;
        push_exp(2 + L + 1 + TO + 1, 1, C1_A, C2_A, 2, {3'd0, 3'd3, 3'd1}, 1, 6, -1);
        start_run(3'd3, 3'd1, E1_B, M_B);
        wait_done(80);
        hang_nth = 0;

        // Normal run right after the abort
        push_exp(5 + 3 * L, 0, C1_B, C2_B, 3, KS_B, 1, 6, 11);
        start_run(3'd3, 3'd1, E1_B, M_B);
        wait_done(80);

        // Ready held high: each job completes on its first WAIT cycle
        stale = 1'b1;
        push_exp(8, 0, C1_A, C2_A, 3, KS_A, 1, 3, 5);
        start_run(3'd2, 3'd3, E1_A, M_A);
        wait_done(80);
        stale = 1'b0;

        // Reset during S_WAIT (cycle 13), engine ready lands afterwards
        start_run(3'd2, 3'd3, E1_A, M_A);
        repeat (12) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("mid_rst_busy_done", 32'({busy, done, error, eng_if.mul_start}), 0);
        check("mid_rst_mul_ops", 32'({eng_if.mul_k, eng_if.mul_X0, eng_if.mul_Y0,
                                       eng_if.mul_Z0}), 0);
        check("mid_rst_ct", 32'({x_C1, y_C1, z_C1, x_C2, y_C2, z_C2}), 0);
        check("mid_rst_add", 32'({add_X0, add_Y0, add_Z0, add_X1, add_Y1, add_Z1}), 0);
        quiet = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (done || busy || eng_if.mul_start) quiet = 1'b0;
        end
        check("post_rst_quiet", 32'(quiet), 1);

        // Normal run after the mid-job reset
        push_exp(5 + 3 * L, 0, C1_B, C2_B, 3, KS_B, 1, 6, 11);
        start_run(3'd3, 3'd1, E1_B, M_B);
        wait_done(80);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
